// File: rtl/nqcpu_bus_pkg.sv
// Shared types and widths for the nqcpu external bus and its SRAM bridge.
package nqcpu_bus_pkg;

    localparam int CPU_AW     = 24;
    localparam int DW         = 16;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RECOVER
    } bridge_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } bridge_op_t;

endpackage

// File: rtl/sram_wait_timer.sv
// Wait-state counter: loads a start value, counts down to zero and holds there.
module sram_wait_timer
    import nqcpu_bus_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [WAIT_CNT_W-1:0] load_val_i,
    input  logic                  dec_i,
    output logic                  done_o
);

    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    // Load has priority over decrement; counter saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram_bridge.sv
// CPU word-bus to async 16-bit SRAM bridge with programmable wait states.
module sram_bridge
    import nqcpu_bus_pkg::*;
#(
    parameter int SRAM_AW     = 17,
    parameter int WAIT_STATES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CPU_AW-1:0]  cpu_addr_i,
    input  logic               cpu_re_i,
    input  logic               cpu_we_i,
    inout  wire  [DW-1:0]      cpu_data_io,
    output logic               cpu_wait_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    inout  wire  [DW-1:0]      sram_dq_io,
    output logic               bus_err_o
);

    bridge_state_t      state_q, state_d;
    bridge_op_t         op_q, op_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               req;
    logic               t_load, t_dec, t_done;
    logic               unused_addr_hi;

    // Address bits above the SRAM window alias and are intentionally ignored.
    assign unused_addr_hi = ^cpu_addr_i[CPU_AW-1:SRAM_AW+1];

    sram_wait_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (t_load),
        .load_val_i (WAIT_CNT_W'(WAIT_STATES - 1)),
        .dec_i      (t_dec),
        .done_o     (t_done)
    );

    // Next-state, access latching and strobe decode (strobes follow next state).
    always_comb begin
        req     = cpu_re_i | cpu_we_i;
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        t_load  = 1'b0;
        t_dec   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACTIVE;
                    op_d    = cpu_we_i ? OP_WR : OP_RD;
                    addr_d  = cpu_addr_i[SRAM_AW:1];
                    wdata_d = cpu_data_io;
                    t_load  = 1'b1;
                    if (cpu_addr_i[0] || (cpu_re_i && cpu_we_i)) begin
                        err_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                t_dec = 1'b1;
                if (t_done) begin
                    state_d = RECOVER;
                    if (op_q == OP_RD) begin
                        rdata_d = sram_dq_io;
                    end
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ce_n_d = (state_d == IDLE);
        oe_n_d = !((state_d == ACTIVE) && (op_d == OP_RD));
        we_n_d = !((state_d == ACTIVE) && (op_d == OP_WR));
    end

    // State, latches and registered strobes; reset parks everything idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
        end
    end

    assign cpu_wait_o  = req && (rst || (state_q != RECOVER));
    assign sram_addr_o = addr_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign bus_err_o   = err_q;
    assign sram_dq_io  = ((state_q == ACTIVE) && (op_q == OP_WR)) ? wdata_q : 'z;
    assign cpu_data_io = (cpu_re_i && !cpu_we_i) ? rdata_q : 'z;

endmodule

// File: tb/tb_sram_bridge.sv
// Self-checking bench for sram_bridge: vector table, corner sequences, random traffic.
module tb_sram_bridge;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] cpu_addr = '0;
    logic        cpu_re = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_wdata = '0;
    wire  [15:0] cpu_data;
    logic        cpu_wait;
    logic [16:0] sram_addr;
    logic        ce_n, oe_n, we_n, bus_err;
    wire  [15:0] sram_dq;

    logic [23:0] c2_addr = '0;
    logic        c2_re = 1'b0;
    wire  [15:0] c2_data;
    logic        c2_wait;
    logic [16:0] s2_addr;
    logic        s2_ce_n, s2_oe_n, s2_we_n, s2_err;
    wire  [15:0] s2_dq;

    logic [15:0] mem [0:(1<<17)-1];
    logic [15:0] mem_ref [0:255];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_bridge #(.SRAM_AW(17), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .cpu_addr_i(cpu_addr), .cpu_re_i(cpu_re), .cpu_we_i(cpu_we),
        .cpu_data_io(cpu_data), .cpu_wait_o(cpu_wait), .sram_addr_o(sram_addr),
        .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_dq_io(sram_dq),
        .bus_err_o(bus_err)
    );

    sram_bridge #(.SRAM_AW(17), .WAIT_STATES(1)) dut2 (
        .clk(clk), .rst(rst), .cpu_addr_i(c2_addr), .cpu_re_i(c2_re), .cpu_we_i(1'b0),
        .cpu_data_io(c2_data), .cpu_wait_o(c2_wait), .sram_addr_o(s2_addr),
        .sram_ce_n(s2_ce_n), .sram_oe_n(s2_oe_n), .sram_we_n(s2_we_n), .sram_dq_io(s2_dq),
        .bus_err_o(s2_err)
    );

    assign cpu_data = cpu_we ? cpu_wdata : 'z;
    assign sram_dq  = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 'z;
    assign s2_dq    = (!s2_ce_n && !s2_oe_n) ? s2_addr[15:0] : 'z;

    always @(negedge clk) begin
        if (!ce_n && !we_n) mem[sram_addr] = sram_dq;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input int w, input logic [15:0] v);
        mem[w] = v;
        if (w < 256) mem_ref[w] = v;
    endtask

    // One CPU access; also tallies strobe cycles and strobe-cycle address/data errors.
    task automatic access(input logic re, input logic we, input logic [23:0] a,
                          input logic [15:0] d, output logic [15:0] rd, output int cyc,
                          output int we_lo, output int oe_lo, output int bad);
        logic [16:0] w;
        w = a[17:1];
        cpu_addr = a; cpu_re = re; cpu_we = we; cpu_wdata = d;
        cyc = 0; we_lo = 0; oe_lo = 0; bad = 0; rd = '0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (!we_n) begin
                we_lo++;
                if (sram_dq !== d || sram_addr !== w || ce_n) bad++;
            end
            if (!oe_n) begin
                oe_lo++;
                if (sram_addr !== w || ce_n) bad++;
            end
            if (!cpu_wait) begin
                rd = cpu_data;
                if (ce_n || !oe_n || !we_n) bad++;
                break;
            end
            if (cyc >= 64) begin
                chk("access_timeout", 32'(cyc), 32'(WS + 2));
                break;
            end
        end
        @(posedge clk); #1;
        cpu_re = 1'b0; cpu_we = 1'b0;
    endtask

    typedef struct {
        logic        re;
        logic        we;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[9];

    initial begin
        logic [15:0] rd;
        int cyc, we_lo, oe_lo, bad, cnt_oe, cnt_ce, cnt_wait, done_cnt, tot, last;
        logic [31:0] r;
        logic [7:0]  w8;

        for (int i = 0; i < (1 << 17); i++) mem[i] = 16'(i) ^ 16'h5A00;
        for (int i = 0; i < 256; i++) mem_ref[i] = 16'(i) ^ 16'h5A00;
        preload(16'h0010, 16'hBEEF);
        preload(16'h0001, 16'h1111);

        vt[0] = '{1'b1, 1'b0, 24'h000020, 16'h0000, 16'hBEEF, 1'b0};
        vt[1] = '{1'b0, 1'b1, 24'h000040, 16'h1234, 16'h0000, 1'b0};
        vt[2] = '{1'b1, 1'b0, 24'h000040, 16'h0000, 16'h1234, 1'b0};
        vt[3] = '{1'b0, 1'b1, 24'h040006, 16'h5A5A, 16'h0000, 1'b0};
        vt[4] = '{1'b1, 1'b0, 24'h000006, 16'h0000, 16'h5A5A, 1'b0};
        vt[5] = '{1'b1, 1'b0, 24'h000003, 16'h0000, 16'h1111, 1'b1};
        vt[6] = '{1'b1, 1'b1, 24'h000008, 16'h7777, 16'h0000, 1'b1};
        vt[7] = '{1'b1, 1'b0, 24'h000008, 16'h0000, 16'h7777, 1'b1};
        vt[8] = '{1'b1, 1'b0, 24'h000040, 16'h0000, 16'h1234, 1'b1};

        // Reset: stall mirrors request while rst is high; outputs at reset values.
        cpu_re = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wait_follows_req", 32'(cpu_wait), 32'd1);
        @(posedge clk); #1;
        cpu_re = 1'b0;
        @(negedge clk);
        chk("rst_wait_idle", 32'(cpu_wait), 32'd0);
        chk("rst_strobes", {29'd0, ce_n, oe_n, we_n}, 32'h7);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Vector table.
        foreach (vt[i]) begin
            access(vt[i].re, vt[i].we, vt[i].addr, vt[i].wdata, rd, cyc, we_lo, oe_lo, bad);
            if (vt[i].we && vt[i].addr[17:9] == '0) mem_ref[vt[i].addr[8:1]] = vt[i].wdata;
            chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(WS + 2));
            chk($sformatf("vec%0d_we_low", i), 32'(we_lo), vt[i].we ? 32'(WS) : 32'd0);
            chk($sformatf("vec%0d_oe_low", i), 32'(oe_lo), (vt[i].re && !vt[i].we) ? 32'(WS) : 32'd0);
            chk($sformatf("vec%0d_strobe_cycles", i), 32'(bad), 32'd0);
            chk($sformatf("vec%0d_bus_err", i), 32'(bus_err), 32'(vt[i].exp_err));
            if (vt[i].re && !vt[i].we)
                chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vt[i].exp_rd));
        end

        // Reset during the second ACTIVE cycle of a write.
        cpu_addr = 24'h000400; cpu_we = 1'b1; cpu_wdata = 16'hDEAD;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_we_active", 32'(we_n), 32'd0);
        chk("midrst_wait_high", 32'(cpu_wait), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        chk("midrst_strobes", {29'd0, ce_n, oe_n, we_n}, 32'h7);
        chk("midrst_err_cleared", 32'(bus_err), 32'd0);
        chk("midrst_wait_idle", 32'(cpu_wait), 32'd0);
        @(posedge clk); #1;
        access(1'b1, 1'b0, 24'h000020, 16'h0, rd, cyc, we_lo, oe_lo, bad);
        chk("postrst_cycles", 32'(cyc), 32'(WS + 2));
        chk("postrst_rdata", 32'(rd), 32'hBEEF);

        // Read request dropped after acceptance still runs the full access.
        cpu_addr = 24'h000020; cpu_re = 1'b1;
        @(posedge clk); #1;
        cpu_re = 1'b0;
        cnt_oe = 0; cnt_ce = 0; cnt_wait = 0;
        repeat (5) begin
            @(negedge clk);
            if (!oe_n) cnt_oe++;
            if (!ce_n) cnt_ce++;
            if (cpu_wait) cnt_wait++;
        end
        chk("drop_oe_cycles", 32'(cnt_oe), 32'(WS));
        chk("drop_ce_cycles", 32'(cnt_ce), 32'(WS + 1));
        chk("drop_no_wait", 32'(cnt_wait), 32'd0);
        @(posedge clk); #1;

        // Random traffic against the array model.
        for (int n = 0; n < 40; n++) begin
            logic        isw;
            logic [23:0] a;
            logic [15:0] d;
            r   = $urandom;
            w8  = 8'($urandom_range(0, 255));
            isw = 1'($urandom_range(0, 1));
            d   = 16'($urandom);
            a   = {r[5:0], 9'd0, w8, 1'b0};
            access(!isw, isw, a, d, rd, cyc, we_lo, oe_lo, bad);
            chk($sformatf("rnd%0d_cycles", n), 32'(cyc), 32'(WS + 2));
            if (isw) mem_ref[w8] = d;
            else chk($sformatf("rnd%0d_rdata", n), 32'(rd), 32'(mem_ref[w8]));
        end
        chk("rnd_err_clear", 32'(bus_err), 32'd0);

        // Back-to-back reads on the single-wait-state bridge.
        c2_addr = 24'h0; c2_re = 1'b1;
        done_cnt = 0; tot = 0; last = 0;
        while (done_cnt < 3 && tot < 64) begin
            @(negedge clk);
            tot++;
            if (!c2_wait) begin
                chk($sformatf("b2b%0d_oe_recover", done_cnt), 32'(s2_oe_n), 32'd1);
                chk($sformatf("b2b%0d_rdata", done_cnt), 32'(c2_data), 32'(done_cnt));
                chk($sformatf("b2b%0d_cycles", done_cnt), 32'(tot - last), 32'd3);
                last = tot;
                done_cnt++;
                @(posedge clk); #1;
                c2_addr = 24'(done_cnt * 2);
                if (done_cnt == 3) c2_re = 1'b0;
            end
        end
        chk("b2b_total_cycles", 32'(tot), 32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
